timer_ctrl: RTL and testbench

//   Sequencer for the free-running W-bit timer counter datapath: drives the counter's

---
 rtl/timer_ctrl.sv | 116 +++++++++++
 tb/tb_timer_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Timer sequencer: drives enable/clear of an external W-bit counter with a prescaler,
// a compare match, one-shot or periodic operation, a match tick and a sticky expired flag.
module timer_ctrl #(
    parameter int unsigned W  = 8,
    parameter int unsigned PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          mode,
    input  logic [PW-1:0] prescale,
    input  logic [W-1:0]  compare,
    input  logic          irq_clr,
    input  logic [W-1:0]  cnt_q,
    output logic          cnt_en,
    output logic          cnt_clr,
    output logic          busy,
    output logic          tick,
    output logic          expired
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_cnt_q;
    logic [PW-1:0] pre_q;
    logic [W-1:0]  cmp_q;
    logic          mode_q;
    logic          tick_q;
    logic          expired_q;
    logic          step;
    logic          match;
    logic [W-1:0]  cnt_inc;

    // Step and match decode; cmp_q == 0 matches on the wrap to zero.
    always_comb begin
        cnt_inc = cnt_q + W'(1);
        step    = (state_q == RUN) && (pre_cnt_q == pre_q);
        match   = step && (cnt_inc == cmp_q);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and counter controls; stop has priority over start.
    always_comb begin
        state_d = state_q;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        busy    = 1'b0;

        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = ARM;
        end else begin
            case (state_q)
                ARM:     state_d = RUN;
                RUN:     if (match && !mode_q) state_d = DONE;
                default: state_d = state_q;
            endcase
        end

        busy    = (state_q == ARM) || (state_q == RUN);
        cnt_en  = step;
        cnt_clr = (state_q == ARM) || (match && mode_q);
    end

    // Shadow config, prescaler phase and match flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q     <= '0;
            cmp_q     <= '0;
            mode_q    <= 1'b0;
            pre_cnt_q <= '0;
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            if (start && !stop) begin
                pre_q  <= prescale;
                cmp_q  <= compare;
                mode_q <= mode;
            end

            if (state_q == RUN) begin
                pre_cnt_q <= (pre_cnt_q == pre_q) ? '0 : pre_cnt_q + PW'(1);
            end else begin
                pre_cnt_q <= '0;
            end

            tick_q <= match;

            if (match) begin
                expired_q <= 1'b1;
            end else if (irq_clr) begin
                expired_q <= 1'b0;
            end
        end
    end

    assign tick    = tick_q;
    assign expired = expired_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios plus random traffic, checked each cycle
// against a behavioural timer model and an external counter register.
module tb_timer_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned PW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, stop, mode, irq_clr;
    logic [PW-1:0] prescale;
    logic [W-1:0]  compare;
    logic [W-1:0]  cnt_q = '0;
    logic          cnt_en, cnt_clr, busy, tick, expired;

    int n_checks = 0;
    int n_pass   = 0;

    // Stats gathered over a directed scenario.
    int cyc_idx, n_en, n_tick, tick_at;

    // Behavioural model: phase 0 idle, 1 arm, 2 run, 3 done.
    int ph, run_cyc, m_pre, m_cmp, m_cnt;
    bit m_mode, m_tick, m_exp;

    timer_ctrl #(.W(W), .PW(PW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .prescale (prescale),
        .compare  (compare),
        .irq_clr  (irq_clr),
        .cnt_q    (cnt_q),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .busy     (busy),
        .tick     (tick),
        .expired  (expired)
    );

    always #5 clk = ~clk;

    // External counter register following the datapath contract.
    always @(posedge clk) begin
        cnt_q <= cnt_clr ? '0 : cnt_en ? cnt_q + W'(1) : cnt_q;
    end

    function automatic bit e_en();
        return (ph == 2) && ((run_cyc % (m_pre + 1)) == m_pre);
    endfunction

    function automatic bit e_match();
        return e_en() && (((m_cnt + 1) % 256) == m_cmp);
    endfunction

    function automatic bit e_clr();
        return (ph == 1) || (e_match() && m_mode);
    endfunction

    task automatic model_reset();
        ph = 0; run_cyc = 0; m_pre = 0; m_cmp = 0; m_mode = 0; m_tick = 0; m_exp = 0;
    endtask

    task automatic model_step(input bit s, input bit sp, input bit m, input int p,
                              input int c, input bit ic);
        bit en, mt, clr;
        en  = e_en();
        mt  = e_match();
        clr = e_clr();
        m_tick = mt;
        m_exp  = mt ? 1'b1 : (ic ? 1'b0 : m_exp);
        m_cnt  = clr ? 0 : (en ? (m_cnt + 1) % 256 : m_cnt);
        if (sp) begin
            ph = 0;
        end else if (s) begin
            ph = 1; m_mode = m; m_pre = p; m_cmp = c;
        end else if (ph == 1) begin
            ph = 2; run_cyc = 0;
        end else if (ph == 2) begin
            if (mt && !m_mode) ph = 3;
            else run_cyc++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic clr_stats();
        cyc_idx = 0; n_en = 0; n_tick = 0; tick_at = -1;
    endtask

    // One clock cycle: drive, check at negedge against the model, advance at posedge.
    task automatic cyc(input bit s, input bit sp, input bit m, input logic [PW-1:0] p,
                       input logic [W-1:0] c, input bit ic);
        start = s; stop = sp; mode = m; prescale = p; compare = c; irq_clr = ic;
        @(negedge clk);
        check("cnt_en",  32'(cnt_en),  32'(e_en()));
        check("cnt_clr", 32'(cnt_clr), 32'(e_clr()));
        check("busy",    32'(busy),    32'(ph == 1 || ph == 2));
        check("tick",    32'(tick),    32'(m_tick));
        check("expired", 32'(expired), 32'(m_exp));
        check("cnt_q",   32'(cnt_q),   32'(m_cnt));
        if (cnt_en) n_en++;
        if (tick) begin n_tick++; tick_at = cyc_idx; end
        cyc_idx++;
        @(posedge clk);
        model_step(s, sp, m, int'(p), int'(c), ic);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'd0, 8'd0, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 0; stop = 0; mode = 0; irq_clr = 0;
        prescale = '0; compare = '0;
        model_reset();
        m_cnt = 0;
        #1;
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_cnt_en",  32'(cnt_en),  32'd0);
        check("rst_cnt_clr", 32'(cnt_clr), 32'd0);
        check("rst_tick",    32'(tick),    32'd0);
        check("rst_expired", 32'(expired), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(3);

        // One-shot, prescale 0, compare 5.
        clr_stats();
        cyc(1, 0, 0, 8'd0, 8'd5, 0);
        idle(11);
        check("os5_en_count", 32'(n_en),   32'd5);
        check("os5_ticks",    32'(n_tick), 32'd1);
        check("os5_tick_at",  32'(tick_at), 32'd7);
        check("os5_cnt",      32'(cnt_q),  32'd5);
        check("os5_busy",     32'(busy),   32'd0);
        check("os5_expired",  32'(expired), 32'd1);
        cyc(0, 0, 0, 8'd0, 8'd0, 1);
        check("os5_irq_clr",  32'(expired), 32'd0);

        // Periodic, prescale 2, compare 3: ticks at 11, 20, 29, 38.
        clr_stats();
        cyc(1, 0, 1, 8'd2, 8'd3, 0);
        idle(39);
        check("per_ticks",   32'(n_tick),  32'd4);
        check("per_last",    32'(tick_at), 32'd38);
        check("per_en",      32'(n_en),    32'd12);
        check("per_busy",    32'(busy),    32'd1);
        cyc(0, 1, 0, 8'd0, 8'd0, 0);
        cyc(0, 0, 0, 8'd0, 8'd0, 1);
        check("per_stopped", 32'(busy),    32'd0);

        // One-shot, compare 0: full 256-step wrap.
        clr_stats();
        cyc(1, 0, 0, 8'd0, 8'd0, 0);
        idle(269);
        check("wrap_en_count", 32'(n_en),    32'd256);
        check("wrap_ticks",    32'(n_tick),  32'd1);
        check("wrap_tick_at",  32'(tick_at), 32'd258);
        check("wrap_cnt",      32'(cnt_q),   32'd0);
        cyc(0, 0, 0, 8'd0, 8'd0, 1);

        // Stop at cnt_q == 2 (prescale 3, steps at idx 5, 9, 13).
        clr_stats();
        cyc(1, 0, 0, 8'd3, 8'd10, 0);
        idle(9);
        cyc(0, 1, 0, 8'd0, 8'd0, 0);
        idle(10);
        check("stop_cnt",   32'(cnt_q),  32'd2);
        check("stop_ticks", 32'(n_tick), 32'd0);
        check("stop_busy",  32'(busy),   32'd0);
        cyc(1, 1, 0, 8'd0, 8'd4, 0);
        check("startstop_busy", 32'(busy), 32'd0);
        idle(3);

        // irq_clr on the match cycle; compare changes during RUN are ignored.
        clr_stats();
        cyc(1, 0, 0, 8'd0, 8'd3, 0);
        for (int i = 1; i < 8; i++) cyc(0, 0, 0, 8'd5, 8'hAA, i == 4);
        check("irq_tick_at", 32'(tick_at), 32'd5);
        check("irq_expired", 32'(expired), 32'd1);
        check("irq_cnt",     32'(cnt_q),   32'd3);
        cyc(0, 0, 0, 8'd0, 8'd0, 1);
        check("irq_later",   32'(expired), 32'd0);

        // Asynchronous reset mid-RUN.
        cyc(1, 0, 1, 8'd0, 8'd4, 0);
        idle(8);
        check("pre_rst_busy", 32'(busy),    32'd1);
        check("pre_rst_exp",  32'(expired), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",    32'(busy),    32'd0);
        check("arst_cnt_en",  32'(cnt_en),  32'd0);
        check("arst_cnt_clr", 32'(cnt_clr), 32'd0);
        check("arst_tick",    32'(tick),    32'd0);
        check("arst_expired", 32'(expired), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        m_cnt = int'(cnt_q);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clr_stats();
        idle(6);
        check("post_rst_en", 32'(n_en), 32'd0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            bit s, sp;
            s  = ($urandom_range(0, 99) < 4);
            sp = ($urandom_range(0, 99) < 2);
            cyc(s, sp, 1'($urandom_range(0, 1)),
                s ? 8'($urandom_range(0, 3)) : 8'($urandom),
                s ? 8'($urandom_range(0, 7)) : 8'($urandom),
                ($urandom_range(0, 99) < 6));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
